// File: rtl/game_flow_ctrl.sv
// Game flow controller: sequences load/arm/aim/fly with pause, lives and level
// tracking, and derives the ball step period from launch angle and level.
//
// Ports:
//   clk     - clock, all logic on rising edge
//   rst     - synchronous active-high reset
//   circle  - launch/confirm pulse
//   pause   - pause toggle pulse
//   dead    - ball lost
//   win     - all bricks cleared
//   angle   - launch direction (1 or 4 = steep)
//   state   - current state encoding
//   period  - ball step period in clk cycles
//   level   - current level index
//   lives   - balls remaining
//   load    - high while state == LOAD (combinational decode)
module game_flow_ctrl #(
    parameter int unsigned NUM_LEVELS     = 4,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned PERIOD_W       = 20,
    parameter int unsigned PERIOD_STEEP   = 100000,
    parameter int unsigned PERIOD_SHALLOW = 130000,
    parameter int unsigned PERIOD_STEP    = 10000,
    parameter int unsigned PERIOD_MIN     = 60000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          circle,
    input  logic                          pause,
    input  logic                          dead,
    input  logic                          win,
    input  logic [2:0]                    angle,
    output logic [2:0]                    state,
    output logic [PERIOD_W-1:0]           period,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [3:0]                    lives,
    output logic                          load
);

    localparam int unsigned LEVEL_W = $clog2(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ARM   = 3'd1,
        S_AIM   = 3'd2,
        S_FLY   = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      st;
    logic [31:0] base;
    logic [31:0] step_total;
    logic [31:0] aim_period;

    // Aim period: base minus per-level reduction, clamped at the floor without wrap
    always_comb begin
        base       = ((angle == 3'd1) || (angle == 3'd4)) ? 32'(PERIOD_STEEP)
                                                          : 32'(PERIOD_SHALLOW);
        step_total = 32'(level) * 32'(PERIOD_STEP);
        if (base < step_total + 32'(PERIOD_MIN)) begin
            aim_period = 32'(PERIOD_MIN);
        end else begin
            aim_period = base - step_total;
        end
    end

    // Flow state machine with registered counters and period
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= S_LOAD;
            level  <= '0;
            lives  <= 4'(LIVES);
            period <= PERIOD_W'(PERIOD_SHALLOW);
        end else begin
            case (st)
                S_LOAD: st <= S_ARM;
                S_ARM:  st <= S_AIM;
                S_AIM: begin
                    period <= PERIOD_W'(aim_period);
                    if (circle) begin
                        st <= S_FLY;
                    end
                end
                S_FLY: begin
                    if (win) begin
                        if (level == LAST_LEVEL) begin
                            st <= S_DONE;
                        end else begin
                            level <= level + LEVEL_W'(1);
                            st    <= S_LOAD;
                        end
                    end else if (dead) begin
                        // Lives never go below zero; the last ball ends the game
                        if (lives <= 4'd1) begin
                            lives <= 4'd0;
                            st    <= S_OVER;
                        end else begin
                            lives <= lives - 4'd1;
                            st    <= S_AIM;
                        end
                    end else if (pause) begin
                        st <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        st <= S_FLY;
                    end
                end
                S_OVER, S_DONE: begin
                    if (circle) begin
                        level <= '0;
                        lives <= 4'(LIVES);
                        st    <= S_LOAD;
                    end
                end
                default: st <= S_LOAD;
            endcase
        end
    end

    assign state = st;
    assign load  = (st == S_LOAD);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances share stimulus (default step and a
// 20000 step to exercise the period floor); vectors feed a scoreboard queue.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        circle = 1'b0;
    logic        pause = 1'b0;
    logic        dead = 1'b0;
    logic        win = 1'b0;
    logic [2:0]  angle = 3'd1;

    logic [2:0]  state_a, state_b;
    logic [19:0] period_a, period_b;
    logic [1:0]  level_a, level_b;
    logic [3:0]  lives_a, lives_b;
    logic        load_a, load_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_flow_ctrl dut_a (
        .clk(clk), .rst(rst), .circle(circle), .pause(pause), .dead(dead),
        .win(win), .angle(angle), .state(state_a), .period(period_a),
        .level(level_a), .lives(lives_a), .load(load_a)
    );

    game_flow_ctrl #(.PERIOD_STEP(20000)) dut_b (
        .clk(clk), .rst(rst), .circle(circle), .pause(pause), .dead(dead),
        .win(win), .angle(angle), .state(state_b), .period(period_b),
        .level(level_b), .lives(lives_b), .load(load_b)
    );

    typedef struct packed {
        logic        r, c, p, d, w;
        logic [2:0]  a;
        logic [2:0]  st;
        logic [1:0]  lv;
        logic [3:0]  li;
        logic        chk;
        logic [19:0] per;
        logic [19:0] per2;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic r, c, p, d, w, input logic [2:0] a,
                                input logic [2:0] st, input logic [1:0] lv,
                                input logic [3:0] li, input logic chk,
                                input int unsigned per, input int unsigned per2);
        vec_t v;
        v.r = r; v.c = c; v.p = p; v.d = d; v.w = w; v.a = a;
        v.st = st; v.lv = lv; v.li = li; v.chk = chk;
        v.per = 20'(per); v.per2 = 20'(per2);
        return v;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the edge
    task automatic step(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.r; circle = v.c; pause = v.p; dead = v.d; win = v.w; angle = v.a;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d state", idx), 32'(state_a), 32'(e.st));
        check($sformatf("v%0d level", idx), 32'(level_a), 32'(e.lv));
        check($sformatf("v%0d lives", idx), 32'(lives_a), 32'(e.li));
        check($sformatf("v%0d load", idx), 32'(load_a), (e.st == 3'd0) ? 1 : 0);
        check($sformatf("v%0d state_b", idx), 32'(state_b), 32'(e.st));
        if (e.chk) begin
            check($sformatf("v%0d period", idx), 32'(period_a), 32'(e.per));
            check($sformatf("v%0d period_b", idx), 32'(period_b), 32'(e.per2));
        end
    endtask

    initial begin
        //                r  c  p  d  w  a   st lv li chk per     per2
        // reset, then LOAD -> ARM -> AIM, steep period appears one cycle into AIM
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 3, 1, 130000, 130000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 3, 1, 130000, 130000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 1, 130000, 130000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 1, 100000, 100000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0, 3, 1, 100000, 100000));
        // lose all three balls, relaunching in between
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  2, 0, 2, 1, 100000, 100000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0, 2, 1, 100000, 100000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 1, 100000, 100000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0, 3, 0, 0, 0));
        // win and dead together: win takes priority
        tbl.push_back(mk(0, 0, 0, 1, 1, 1,  0, 1, 3, 1, 100000, 100000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 1, 3, 1, 90000, 80000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 1, 3, 0, 0, 0));
        // pause ignores dead, win and circle
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  4, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1,  4, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,  4, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  4, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  3, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,  0, 2, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 2, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 2, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 2, 3, 1, 80000, 60000));
        // level 3: shallow / steep periods and the floor clamp
        tbl.push_back(mk(0, 0, 0, 0, 1, 1,  0, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2,  1, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2,  2, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2,  2, 3, 3, 1, 100000, 70000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4,  2, 3, 3, 1, 70000, 60000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4,  3, 3, 3, 1, 70000, 60000));
        // last level win goes to DONE, which waits for circle
        tbl.push_back(mk(0, 0, 0, 0, 1, 4,  6, 3, 3, 1, 70000, 60000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4,  6, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4,  6, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4,  0, 0, 3, 1, 70000, 60000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0, 3, 1, 100000, 100000));
        // reset mid-FLY overrides a simultaneous win
        tbl.push_back(mk(1, 0, 0, 0, 1, 1,  0, 0, 3, 1, 130000, 130000));

        foreach (tbl[i]) step(i, tbl[i]);

        // Hand-written: lose a ball, pause, then reset while paused
        step(100, mk(0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 0, 0));
        step(101, mk(0, 0, 0, 0, 0, 1,  2, 0, 3, 1, 130000, 130000));
        step(102, mk(0, 1, 0, 0, 0, 1,  3, 0, 3, 1, 100000, 100000));
        step(103, mk(0, 0, 0, 1, 0, 1,  2, 0, 2, 0, 0, 0));
        step(104, mk(0, 1, 0, 0, 0, 1,  3, 0, 2, 0, 0, 0));
        step(105, mk(0, 0, 1, 0, 0, 1,  4, 0, 2, 0, 0, 0));
        step(106, mk(1, 0, 1, 0, 0, 1,  0, 0, 3, 1, 130000, 130000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_LEVELS, default 4, giving the number of playable levels (2..16).
REQ-002 The module SHALL have parameter LIVES, default 3, giving the balls per game (1..15).
REQ-003 The module SHALL have parameter PERIOD_W, default 20, giving the width of period.
REQ-004 The module SHALL have parameters PERIOD_STEEP (default 100000) and PERIOD_SHALLOW (default 130000), giving the base period for steep angles and for all other angles.
REQ-005 The module SHALL have parameters PERIOD_STEP (default 10000) and PERIOD_MIN (default 60000), giving the per-level period reduction and the period floor.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port circle, input, 1 bit: launch/confirm button, a single-cycle debounced pulse.
REQ-009 The module SHALL have port pause, input, 1 bit: pause toggle, a single-cycle debounced pulse.
REQ-010 The module SHALL have ports dead and win, input, 1 bit each: ball lost; all bricks cleared.
REQ-011 The module SHALL have port angle, input, 3 bits: the launch direction chosen by the player.
REQ-012 The module SHALL have port state, output, 3 bits: the current state encoding.
REQ-013 The module SHALL have port period, output, PERIOD_W bits: the ball step period in clk cycles.
REQ-014 The module SHALL have port level, output, clog2(NUM_LEVELS) bits: the current level index.
REQ-015 The module SHALL have port lives, output, 4 bits: balls remaining.
REQ-016 The module SHALL have port load, output, 1 bit: high exactly while state==LOAD (combinational decode).

Function
REQ-017 The state encodings SHALL be LOAD=0, ARM=1, AIM=2, FLY=3, PAUSE=4, OVER=5, DONE=6; encoding 7 SHALL transition to LOAD on the next cycle.
REQ-018 LOAD SHALL advance to ARM, and ARM SHALL advance to AIM, each unconditionally after one cycle.
REQ-019 In AIM, period SHALL be registered every cycle from base = PERIOD_STEEP if angle is 1 or 4, else PERIOD_SHALLOW.
REQ-020 The AIM period value SHALL be base - level*PERIOD_STEP, clamped to PERIOD_MIN when base < level*PERIOD_STEP + PERIOD_MIN, computed without wrap.
REQ-021 The AIM period update SHALL have one-cycle latency: period reflects the angle and level sampled on the previous edge.
REQ-022 AIM SHALL go to FLY when circle=1; period keeps its last AIM value.
REQ-023 Period SHALL hold in every state other than AIM.
REQ-024 FLY SHALL resolve simultaneous events with priority win > dead > pause.
REQ-025 In FLY, win with level==NUM_LEVELS-1 SHALL go to DONE with level unchanged.
REQ-026 In FLY, win otherwise SHALL increment level and go to LOAD.
REQ-027 In FLY, dead SHALL decrement lives; if lives was 1, the next state SHALL be OVER (lives=0), else AIM.
REQ-028 In FLY, pause SHALL go to PAUSE.
REQ-029 In PAUSE, a pause pulse SHALL return to FLY; win, dead and circle SHALL be ignored.
REQ-030 OVER and DONE SHALL hold until circle=1, then set level=0, lives=LIVES and go to LOAD (new game).
REQ-031 circle SHALL be ignored in LOAD, ARM, FLY and PAUSE; pause SHALL be ignored outside FLY and PAUSE; win and dead SHALL be ignored outside FLY.
REQ-032 Lives SHALL never underflow and level SHALL never exceed NUM_LEVELS-1.

Reset
REQ-033 While rst=1 at a clk edge, the module SHALL set state=LOAD, level=0, lives=LIVES and period=PERIOD_SHALLOW; load reads 1 during reset.
REQ-034 Reset asserted in any state, including mid-FLY or PAUSE, SHALL override all other inputs in that cycle.

Verification
REQ-035 The bench SHALL apply reset, release it, and hold angle=1: state SHALL be 0,1,2 on successive cycles, load=1 only in the first, and period=100000 one cycle after entering AIM.
REQ-036 The bench SHALL bring level to 3 in AIM: angle=2 SHALL give period=100000 and angle=4 SHALL give 70000; with PERIOD_STEP=20000, angle=4 SHALL give 60000 (clamp).
REQ-037 The bench SHALL pulse dead in FLY three times, relaunching each time: lives SHALL go 3→2→1 returning to AIM, then 0 with state=OVER; a circle pulse SHALL then give level=0, lives=3, state=LOAD.
REQ-038 The bench SHALL assert win and dead in the same FLY cycle at level 0: level SHALL become 1, lives SHALL stay 3, and state SHALL be LOAD.
REQ-039 The bench SHALL pulse pause in FLY, then pulse dead and win while paused: state SHALL stay 4 with no counter change; a second pause pulse SHALL return to 3.
REQ-040 The bench SHALL pulse win in FLY at level 3 with NUM_LEVELS=4: state SHALL become 6 with level=3; asserting rst mid-FLY on a separate run SHALL give state=0 the next cycle.
